// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//
// Handshaked ALU with an iterative multiply/divide unit.
//   * Ops 0..15 and 20..31 finish in one cycle: the result is registered on the
//     accept edge and out_valid rises right after it.
//   * Ops 16..19 (MUL, MULHU, DIVU, REMU) take DATA_WIDTH iterations. Each
//     iteration handles one bit. They share one 2*DATA_WIDTH-bit accumulator:
//     shift-add for multiply, restoring division for divide.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   ALU_Op      operation select (5 bits), captured on accept
//   operand_A   first operand (DATA_WIDTH bits), captured on accept
//   operand_B   second operand (DATA_WIDTH bits), captured on accept
//   in_valid    request valid
//   in_ready    request ready; accept = in_valid & in_ready at an edge
//   out_valid   response valid (high exactly in DONE)
//   out_ready   response ready; consume = out_valid & out_ready at an edge
//   ALU_result  registered result
//   zero        registered flag, high when ALU_result == 0
//   busy        high while an iterative op is running
// -----------------------------------------------------------------------------
module alu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            ALU_Op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  zero,
  output logic                  busy
);

  localparam int W     = DATA_WIDTH;
  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = $clog2(W);

  localparam logic [W-1:0]     W_VAL    = W'(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured context of the iterative op in flight.
  logic             r_op_div;   // 1: divide family, 0: multiply family
  logic             r_op_hi;    // 1: return upper half of the accumulator
  logic [W-1:0]     r_opnd;     // multiplicand (mul) or divisor (div)
  logic [2*W-1:0]   r_acc;      // product / remainder:quotient register
  logic [CNT_W-1:0] r_cnt;      // iteration counter

  logic [W-1:0]     r_result;
  logic             r_zero;

  logic             w_accept;
  logic             w_is_multi;
  logic             w_last;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (operates on the live inputs; used only on accept)
  // ---------------------------------------------------------------------------
  logic            w_shamt_big;
  logic [SH_W-1:0] w_shamt;
  logic            w_lt;
  logic            w_eq;
  logic [W-1:0]    w_single;

  assign w_shamt_big = (operand_B >= W_VAL);
  // When the amount is below W it fits entirely in the low SH_W bits.
  assign w_shamt     = operand_B[SH_W-1:0];
  assign w_lt        = (operand_A < operand_B);
  assign w_eq        = (operand_A == operand_B);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_single = '0;
    unique case (ALU_Op)
      5'd0:    w_single = operand_A + operand_B;
      5'd1:    w_single = operand_A & operand_B;
      5'd2:    w_single = ~(operand_A | operand_B);
      5'd3:    w_single = operand_A | operand_B;
      5'd4:    w_single = w_shamt_big ? '0 : (operand_A << w_shamt);
      5'd5:    w_single = {{(W-1){1'b0}}, w_lt};
      5'd6:    w_single = w_shamt_big ? '0 : (operand_A >> w_shamt);
      5'd7:    w_single = w_shamt_big ? {W{operand_A[W-1]}}
                                      : W'($signed(operand_A) >>> w_shamt);
      5'd8:    w_single = operand_A - operand_B;
      5'd9:    w_single = operand_A ^ operand_B;
      // Compare ops report 0 when their relation holds.
      5'd10:   w_single = {{(W-1){1'b0}}, ~w_eq};
      5'd11:   w_single = {{(W-1){1'b0}},  w_lt};
      5'd12:   w_single = {{(W-1){1'b0}},  (w_lt | w_eq)};
      5'd13:   w_single = {{(W-1){1'b0}}, ~(w_lt | w_eq)};
      5'd14:   w_single = {{(W-1){1'b0}}, ~w_lt};
      5'd15:   w_single = {{(W-1){1'b0}},  w_eq};
      default: w_single = '0;  // 16..19 go through the iterative path; 20..31 are 0
    endcase
  end

  assign w_is_multi = (ALU_Op[4:2] == 3'b100);

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide step
  // ---------------------------------------------------------------------------
  // Multiply: the accumulator starts as {0, B}. Each step adds A to the upper
  // half when the current LSB is set, then shifts the whole register right.
  // The extra sum bit carries into the vacated MSB.
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Restoring divide: the accumulator starts as {0, A}. Each step shifts left,
  // trial-subtracts the divisor from the upper half, and shifts the quotient
  // bit into the LSB. With a zero divisor every trial succeeds, which gives an
  // all-ones quotient and leaves A in the remainder half.
  logic [W:0]     w_div_trial;
  logic [W:0]     w_div_diff;
  logic           w_div_ge;
  logic [2*W-1:0] w_div_next;

  assign w_div_trial = r_acc[2*W-1:W-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
  assign w_div_next  = {(w_div_ge ? w_div_diff[W-1:0] : w_div_trial[W-1:0]),
                        r_acc[W-2:0], w_div_ge};

  logic [2*W-1:0] w_acc_next;
  logic [W-1:0]   w_multi_result;

  assign w_acc_next     = r_op_div ? w_div_next : w_mul_next;
  // MUL/DIVU take the low half; MULHU/REMU take the high half.
  assign w_multi_result = r_op_hi ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0];
  assign w_last         = (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = w_is_multi ? BUSY : DONE;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Under backpressure the response holds and no new request enters.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_state_next = w_is_multi ? BUSY : DONE;
          else          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the datapath is cleared together with the FSM. An op abandoned by
      // reset must leave nothing behind, and the visible result must read 0.
      r_result <= '0;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op_div <= 1'b0;
      r_op_hi  <= 1'b0;
    end else if (w_accept) begin
      if (w_is_multi) begin
        r_op_div <= ALU_Op[1];
        r_op_hi  <= ALU_Op[0];
        r_cnt    <= '0;
        r_opnd   <= ALU_Op[1] ? operand_B : operand_A;
        r_acc    <= {{W{1'b0}}, (ALU_Op[1] ? operand_A : operand_B)};
      end else begin
        r_result <= w_single;
        r_zero   <= (w_single == '0);
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_multi_result;
        r_zero   <= (w_multi_result == '0);
      end
    end
  end

  assign ALU_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//
// Bench for alu_muldiv at DATA_WIDTH = 32. A transaction-level model tracks the
// one outstanding response. It computes the expected result with plain
// arithmetic and the ready cycle from the op latency. A negedge compare
// process checks the DUT against the model on every cycle. Directed
// operations with literal results pin down the model, followed by a long
// randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [4:0]   ALU_Op;
  logic [W-1:0] operand_A;
  logic [W-1:0] operand_B;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_result;
  logic         zero;
  logic         busy;

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .ALU_Op     (ALU_Op),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_result (ALU_result),
    .zero       (zero),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a & b;
      5'd2:  return ~(a | b);
      5'd3:  return a | b;
      5'd4:  return (b >= 32) ? 32'd0 : (a << b);
      5'd5:  return (a < b) ? 32'd1 : 32'd0;
      5'd6:  return (b >= 32) ? 32'd0 : (a >> b);
      5'd7:  return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
      5'd8:  return a - b;
      5'd9:  return a ^ b;
      5'd10: return (a == b) ? 32'd0 : 32'd1;
      5'd11: return (a >= b) ? 32'd0 : 32'd1;
      5'd12: return (a >  b) ? 32'd0 : 32'd1;
      5'd13: return (a <= b) ? 32'd0 : 32'd1;
      5'd14: return (a <  b) ? 32'd0 : 32'd1;
      5'd15: return (a != b) ? 32'd0 : 32'd1;
      5'd16: return p[31:0];
      5'd17: return p[63:32];
      5'd18: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd19: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction model: at most one response outstanding, valid from m_rdy on.
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  bit          m_pending = 1'b0;
  int          m_rdy = 0;
  logic [31:0] m_res = '0;
  bit          started = 1'b0;
  bit          mv_now, mr_now, m_acc, m_cons;

  always @(posedge clock) begin
    mv_now = m_pending && (cyc >= m_rdy);
    mr_now = !m_pending || (mv_now && out_ready);
    m_acc  = in_valid && mr_now;
    m_cons = mv_now && out_ready;
    if (reset) begin
      m_pending = 1'b0;
    end else begin
      if (m_cons) m_pending = 1'b0;
      if (m_acc) begin
        m_pending = 1'b1;
        m_rdy     = cyc + 1 + ((ALU_Op >= 5'd16 && ALU_Op <= 5'd19) ? W : 0);
        m_res     = ref_alu(ALU_Op, operand_A, operand_B);
      end
    end
    cyc++;
  end

  bit e_valid, e_busy, e_ready;

  always @(negedge clock) begin
    if (started && !reset) begin
      e_valid = m_pending && (cyc >= m_rdy);
      e_busy  = m_pending && (cyc < m_rdy);
      e_ready = !m_pending || (e_valid && out_ready);
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("busy",      64'(busy),      64'(e_busy));
      check("in_ready",  64'(in_ready),  64'(e_ready));
      if (e_valid) begin
        check("result", 64'(ALU_result), 64'(m_res));
        check("zero",   64'(zero),       64'(m_res == 0));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    @(posedge clock); #1;
    ALU_Op = op; operand_A = a; operand_B = b; in_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (in_ready === 1'b1) got = 1'b1;
    end
    check("accept_wait", 64'(got), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    // Scramble the inputs: captured operands must not follow them.
    ALU_Op = 5'($urandom); operand_A = $urandom; operand_B = $urandom;
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k, nb;
    bit seen;
    k = 0; nb = 0; seen = 1'b0;
    send(op, a, b);
    while (!seen && k < 100) begin
      @(negedge clock);
      k++;
      if (busy === 1'b1) nb++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check({name, "_lat"},  64'(k),          64'(lat));
    check({name, "_busy"}, 64'(nb),         64'(lat - 1));
    check({name, "_res"},  64'(ALU_result), 64'(exp));
    check({name, "_zero"}, 64'(zero),       64'(exp == 0));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 40));
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int nvalid;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALU_Op = '0; operand_A = '0; operand_B = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    started = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_result",    64'(ALU_result), 64'd0);
    check("rst_zero",      64'(zero),       64'd1);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_in_ready",  64'(in_ready),   64'd1);

    // Literal expectations
    do_op("add_wrap",   5'd0,  32'hFFFF_FFFF, 32'd1,          32'd0,          1);
    do_op("mul_lo",     5'd16, 32'h0001_0000, 32'h0001_0000,  32'd0,          33);
    do_op("mulhu",      5'd17, 32'h0001_0000, 32'h0001_0000,  32'd1,          33);
    do_op("divu",       5'd18, 32'd100,       32'd7,          32'd14,         33);
    do_op("remu",       5'd19, 32'd100,       32'd7,          32'd2,          33);
    do_op("divu_by0",   5'd18, 32'd100,       32'd0,          32'hFFFF_FFFF,  33);
    do_op("remu_by0",   5'd19, 32'd100,       32'd0,          32'd100,        33);
    do_op("sra4",       5'd7,  32'h8000_0000, 32'd4,          32'hF800_0000,  1);
    do_op("sra40",      5'd7,  32'h8000_0000, 32'd40,         32'hFFFF_FFFF,  1);
    do_op("sll32",      5'd4,  32'h1234_5678, 32'd32,         32'd0,          1);
    do_op("srl31",      5'd6,  32'h8000_0000, 32'd31,         32'd1,          1);
    do_op("sub_wrap",   5'd8,  32'd0,         32'd1,          32'hFFFF_FFFF,  1);
    do_op("nor0",       5'd2,  32'd0,         32'd0,          32'hFFFF_FFFF,  1);
    do_op("slt",        5'd5,  32'd3,         32'd9,          32'd1,          1);
    do_op("cmp_eq_t",   5'd10, 32'd5,         32'd5,          32'd0,          1);
    do_op("cmp_eq_f",   5'd10, 32'd5,         32'd6,          32'd1,          1);
    do_op("cmp_gt_f",   5'd12, 32'd3,         32'd9,          32'd1,          1);
    do_op("op25",       5'd25, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0,          1);
    do_op("mul_big",    5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,          33);
    do_op("mulhu_big",  5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  33);

    // Backpressure: hold the response for 5 cycles, then consume and accept
    // on the same edge.
    @(posedge clock); #1 out_ready = 1'b0;
    send(5'd1, 32'hF0F0_1234, 32'hFF00_FF0F);
    in_valid = 1'b1; ALU_Op = 5'd9; operand_A = 32'hAAAA_0000; operand_B = 32'h0000_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid",  64'(out_valid),  64'd1);
      check("bp_result", 64'(ALU_result), 64'h00000000_F000_1204);
      check("bp_ready",  64'(in_ready),   64'd0);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    check("bp_next_valid",  64'(out_valid),  64'd1);
    check("bp_next_result", 64'(ALU_result), 64'h00000000_AAAA_5555);

    // Reset in the middle of a divide: nothing may come out afterwards.
    send(5'd18, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid",  64'(out_valid),  64'd0);
    check("mid_rst_busy",   64'(busy),       64'd0);
    check("mid_rst_ready",  64'(in_ready),   64'd1);
    check("mid_rst_result", 64'(ALU_result), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) nvalid++;
    end
    check("mid_rst_stale", 64'(nvalid), 64'd0);

    // Randomized traffic with backpressure and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      reset     = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      ALU_Op    = 5'($urandom_range(0, 31));
      operand_A = rnd_val();
      operand_B = rnd_val();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);
    check("drain_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
